// File: rtl/sequence_extractor.sv
// Recovers a 40-bit marker (8-bit id + 32-bit reseed count) from the chroma samples of a marker line.
// Optional confidence tracking (weak_bits, MAX_WEAK) is built when SEQ_EXTRACT_CONFIDENCE_EN is defined.
module sequence_extractor #(
    parameter logic [9:0] BLACK_LEVEL   = 10'h040,
    parameter logic [9:0] WHITE_LEVEL   = 10'h3AC,
    parameter logic [7:0] EXPECTED_ID   = 8'hA5,
    parameter int         SAMPLE_OFFSET = 0
`ifdef SEQ_EXTRACT_CONFIDENCE_EN
    ,
    parameter int         MAX_WEAK      = 0
`endif
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [9:0]  data_in,
    output logic [31:0] reseed_count,
    output logic [7:0]  id_out,
    output logic        valid,
    output logic        id_match,
    output logic        abort
`ifdef SEQ_EXTRACT_CONFIDENCE_EN
    ,
    output logic [5:0]  weak_bits
`endif
);

    typedef enum logic [1:0] {IDLE, SKIP, ACQUIRE, DONE} state_t;

    localparam logic [10:0] THR    = ({1'b0, BLACK_LEVEL} + {1'b0, WHITE_LEVEL}) >> 1;
    localparam logic [15:0] OFFSET = 16'(SAMPLE_OFFSET);

    state_t      state, state_next;
    logic [10:0] s_cnt, cur_s;
    logic [5:0]  pos, cur_pos;
    logic [4:0]  votes, cur_votes, total;
    logic [39:0] shreg;
    logic [15:0] skip_cnt;
    logic        prev_en, fin, take, abort_c, start, hit, bit_val, id_ok;
`ifdef SEQ_EXTRACT_CONFIDENCE_EN
    logic [5:0]  weak_cnt, cur_weak;
    logic        is_weak;
`endif

    // A new line is only accepted on a rising enable, so a line cut by reset stays ignored.
    assign start     = enable & ~prev_en;
    assign cur_s     = (state == ACQUIRE) ? s_cnt : '0;
    assign cur_pos   = (state == ACQUIRE) ? pos : '0;
    assign cur_votes = (state == ACQUIRE) ? votes : '0;
    assign hit       = cur_s[0] & ({1'b0, data_in} >= THR);
    assign total     = cur_votes + {4'd0, hit};
    assign bit_val   = (total >= 5'd10);
`ifdef SEQ_EXTRACT_CONFIDENCE_EN
    assign cur_weak  = (state == ACQUIRE) ? weak_cnt : '0;
    assign is_weak   = (total >= 5'd7) && (total <= 5'd11);
    assign id_ok     = (shreg[39:32] == EXPECTED_ID) && (weak_cnt <= 6'(MAX_WEAK));
`else
    assign id_ok     = (shreg[39:32] == EXPECTED_ID);
`endif

    always_ff @(posedge clock) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        take       = 1'b0;
        abort_c    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (SAMPLE_OFFSET > 0) begin
                        state_next = SKIP;
                    end else begin
                        take       = 1'b1;
                        state_next = ACQUIRE;
                    end
                end
            end
            SKIP: begin
                if (!enable) begin
                    state_next = IDLE;
                end else if (skip_cnt == OFFSET) begin
                    take       = 1'b1;
                    state_next = ACQUIRE;
                end
            end
            ACQUIRE: begin
                if (!enable) begin
                    abort_c    = 1'b1;
                    state_next = IDLE;
                end else begin
                    take = 1'b1;
                    if (cur_s == 11'd1439) state_next = DONE;
                end
            end
            DONE: begin
                if (!enable) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            s_cnt        <= '0;
            pos          <= '0;
            votes        <= '0;
            shreg        <= '0;
            skip_cnt     <= '0;
            prev_en      <= 1'b1;
            fin          <= 1'b0;
            valid        <= 1'b0;
            abort        <= 1'b0;
            id_out       <= '0;
            id_match     <= 1'b0;
            reseed_count <= '0;
`ifdef SEQ_EXTRACT_CONFIDENCE_EN
            weak_cnt     <= '0;
            weak_bits    <= '0;
`endif
        end else begin
            prev_en <= enable;
            abort   <= abort_c;
            valid   <= fin;
            fin     <= take && (cur_s == 11'd1439);

            if (state == IDLE && start)        skip_cnt <= 16'd1;
            else if (state == SKIP && enable)  skip_cnt <= skip_cnt + 16'd1;

            if (take) begin
                s_cnt <= cur_s + 11'd1;
                if (cur_pos == 6'd35) begin
                    shreg <= {shreg[38:0], bit_val};
                    votes <= '0;
                    pos   <= '0;
                end else begin
                    votes <= total;
                    pos   <= cur_pos + 6'd1;
                end
`ifdef SEQ_EXTRACT_CONFIDENCE_EN
                weak_cnt <= (cur_pos == 6'd35) ? cur_weak + {5'd0, is_weak} : cur_weak;
`endif
            end

            // Publish one cycle after the final sample; shreg already holds all 40 bits.
            if (fin) begin
                id_out   <= shreg[39:32];
                id_match <= id_ok;
                if (id_ok) reseed_count <= shreg[31:0];
`ifdef SEQ_EXTRACT_CONFIDENCE_EN
                weak_bits <= weak_cnt;
`endif
            end
        end
    end

endmodule

// File: tb/tb_sequence_extractor.sv
// Directed bench for sequence_extractor: clean, wrong-id, noisy, aborted, reset and back-to-back lines.
module tb_sequence_extractor;

    localparam logic [9:0] BLACK = 10'h040;
    localparam logic [9:0] WHITE = 10'h3AC;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic [9:0]  data_in = '0;
    logic [31:0] reseed_count;
    logic [7:0]  id_out;
    logic        valid, id_match, abort;
`ifdef SEQ_EXTRACT_CONFIDENCE_EN
    logic [5:0]  weak_bits;
`endif

    sequence_extractor dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .enable       (enable),
        .data_in      (data_in),
        .reseed_count (reseed_count),
        .id_out       (id_out),
        .valid        (valid),
        .id_match     (id_match),
        .abort        (abort)
`ifdef SEQ_EXTRACT_CONFIDENCE_EN
        ,
        .weak_bits    (weak_bits)
`endif
    );

    always #5 clock = ~clock;

    int checks = 0, errors = 0;
    int tb_cyc = 0, valid_cnt = 0, abort_cnt = 0, both_cnt = 0, valid_at = -1, last_cyc = 0;
    int inv [40];
    logic [31:0] vq [$];

    always @(negedge clock) begin
        tb_cyc++;
        if (valid) begin
            valid_cnt++;
            valid_at = tb_cyc;
            vq.push_back(reseed_count);
        end
        if (abort) abort_cnt++;
        if (valid && abort) both_cnt++;
    end

    task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic en, input logic [9:0] d, input logic rn);
        @(negedge clock);
        #1;
        enable  = en;
        data_in = d;
        reset_n = rn;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 10'h000, 1'b1);
    endtask

    task automatic setinv(input int n);
        foreach (inv[i]) inv[i] = n;
    endtask

    // One marker line; inv[k] odd samples of cell k are inverted. Even samples sit at mid-level.
    task automatic line(input logic [39:0] w, input int stop_at, input int rst_at, input int tail);
        for (int s = 0; s < 1440; s++) begin
            logic [9:0] d;
            logic       b;
            int         k, j;
            if (s == stop_at) begin
                drive(1'b0, 10'h200, 1'b1);
                return;
            end
            k = s / 36;
            j = (s % 36) / 2;
            b = w[39 - k];
            if (s % 2 == 1) d = (b ^ (j < inv[k])) ? WHITE : BLACK;
            else            d = 10'h200;
            drive(1'b1, d, (s == rst_at) ? 1'b0 : 1'b1);
            if (s == 1439) last_cyc = tb_cyc;
        end
        repeat (tail) drive(1'b1, 10'h000, 1'b1);
        drive(1'b0, 10'h000, 1'b1);
    endtask

    int v0, a0;

    initial begin
        setinv(0);
        repeat (3) drive(1'b0, 10'h000, 1'b0);
        chk("rst_reseed", reseed_count, 0);
        chk("rst_id", id_out, 0);
        chk("rst_valid", valid, 0);
        chk("rst_match", id_match, 0);
        chk("rst_abort", abort, 0);
        idle(2);

        v0 = valid_cnt;
        line({8'hA5, 32'h12345678}, -1, -1, 3);
        idle(2);
        chk("t1_valid_cnt", valid_cnt - v0, 1);
        chk("t1_latency", valid_at, last_cyc + 2);
        chk("t1_match", id_match, 1);
        chk("t1_id", id_out, 8'hA5);
        chk("t1_reseed", reseed_count, 32'h12345678);

        v0 = valid_cnt;
        line({8'h3C, 32'h9ABCDEF0}, -1, -1, 0);
        idle(2);
        chk("t2_valid_cnt", valid_cnt - v0, 1);
        chk("t2_id", id_out, 8'h3C);
        chk("t2_match", id_match, 0);
        chk("t2_reseed_hold", reseed_count, 32'h12345678);

        setinv(8);
        line({8'hA5, 32'h0F0F1234}, -1, -1, 0);
        idle(2);
        chk("t3_noise8", reseed_count, 32'h0F0F1234);
        chk("t3_noise8_match", id_match, 1);
        inv[39] = 10;
        line({8'hA5, 32'h12345678}, -1, -1, 0);
        idle(2);
        chk("t3_flip10", reseed_count, 32'h12345679);
        inv[39] = 9;
        line({8'hA5, 32'h12345679}, -1, -1, 0);
        idle(2);
        chk("t3_tie", reseed_count, 32'h12345678);
        setinv(0);

        v0 = valid_cnt; a0 = abort_cnt;
        line({8'hA5, 32'hCAFEF00D}, 700, -1, 0);
        idle(3);
        chk("t4_abort_cnt", abort_cnt - a0, 1);
        chk("t4_no_valid", valid_cnt - v0, 0);
        chk("t4_reseed_hold", reseed_count, 32'h12345678);
        chk("t4_id_hold", id_out, 8'hA5);
        line({8'hA5, 32'hCAFEF00D}, -1, -1, 0);
        idle(2);
        chk("t4_next_reseed", reseed_count, 32'hCAFEF00D);
        chk("t4_next_match", id_match, 1);

        v0 = valid_cnt; a0 = abort_cnt;
        line({8'hA5, 32'h0BADBEEF}, -1, 300, 0);
        idle(2);
        chk("t5_reseed", reseed_count, 0);
        chk("t5_id", id_out, 0);
        chk("t5_match", id_match, 0);
        chk("t5_no_valid", valid_cnt - v0, 0);
        chk("t5_no_abort", abort_cnt - a0, 0);

        v0 = valid_cnt;
        vq.delete();
        line({8'hA5, 32'h00000001}, -1, -1, 0);
        line({8'hA5, 32'hFFFFFFFE}, -1, -1, 100);
        idle(2);
        chk("t6_valid_cnt", valid_cnt - v0, 2);
        chk("t6_first", (vq.size() > 0) ? vq[0] : 32'hDEADDEAD, 32'h00000001);
        chk("t6_second", (vq.size() > 1) ? vq[1] : 32'hDEADDEAD, 32'hFFFFFFFE);
        chk("t6_reseed", reseed_count, 32'hFFFFFFFE);

        chk("valid_abort_overlap", both_cnt, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
